ex_mem_req_unit: RTL and testbench

- Parametrised EX-stage memory request generator. Successor to the single-cycle data_sram_en/we path, targeting a split SRAM-like bus: req/addr_ok for requests, data_ok for responses.
- Performs alignment checking (ALE) and size-aware byte-strobe and lane generation.
- Holds each request stable until it is accepted, tracks outstanding transactions, and marks responses of flushed instructions for discard.
- Sits between the EX operand/ALU result and the data bus. Drives ex_ready_go into the EX handshake.

---
 rtl/ex_mem_req_unit.sv | 186 ++++++++++++++++++
 tb/tb_ex_mem_req_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_req_unit.sv
// EX-stage memory request generator for a split req/addr_ok + data_ok SRAM bus.
// Optional performance counters are enabled with `define MEM_REQ_PERF_EN.
module ex_mem_req_unit #(
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ex_valid,
  input  logic                mem_en,
  input  logic                mem_we,
  input  logic [1:0]          mem_size,
  input  logic [31:0]         mem_addr,
  input  logic [DATA_W-1:0]   st_data,
  input  logic                flush,
  input  logic                older_ex,
  input  logic                mem_allowin,
  output logic                data_sram_req,
  output logic                data_sram_wr,
  output logic [1:0]          data_sram_size,
  output logic [DATA_W/8-1:0] data_sram_wstrb,
  output logic [31:0]         data_sram_addr,
  output logic [DATA_W-1:0]   data_sram_wdata,
  input  logic                data_sram_addr_ok,
  input  logic                data_sram_data_ok,
  output logic                ex_ale,
  output logic                ex_ready_go,
  output logic                data_ok_drop,
  output logic [CNT_W-1:0]    outst_cnt,
  output logic [31:0]         perf_req_cnt,
  output logic [31:0]         perf_wait_cnt
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_CANCEL = 2'd3;

  logic [1:0]        r_state, w_nstate;
  logic [CNT_W-1:0]  r_outst, r_cancel;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [NB-1:0]     r_wstrb;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_mis, w_go, w_idle, w_hs, w_cinc, w_drop;
  logic [7:0]        w_mask;
  logic [15:0]       w_mask_sh;
  logic [NB-1:0]     w_wstrb;
  logic [DATA_W-1:0] w_wdata;

  always_comb begin
    w_mis = 1'b0;
    case (mem_size)
      2'd0: w_mis = 1'b0;
      2'd1: w_mis = mem_addr[0];
      2'd2: w_mis = |mem_addr[1:0];
      2'd3: w_mis = (DATA_W == 32) ? 1'b1 : |mem_addr[2:0];
    endcase
  end
  assign ex_ale = ex_valid & mem_en & w_mis;

  always_comb begin
    case (mem_size)
      2'd0:    w_mask = 8'h01;
      2'd1:    w_mask = 8'h03;
      2'd2:    w_mask = 8'h0F;
      default: w_mask = 8'hFF;
    endcase
  end
  assign w_mask_sh = {8'h00, w_mask} << mem_addr[OW-1:0];
  assign w_wstrb   = mem_we ? w_mask_sh[NB-1:0] : '0;

  always_comb begin
    case (mem_size)
      2'd0:    w_wdata = {(DATA_W/8){st_data[7:0]}};
      2'd1:    w_wdata = {(DATA_W/16){st_data[15:0]}};
      2'd2:    w_wdata = {(DATA_W/32){st_data[31:0]}};
      default: w_wdata = st_data;
    endcase
  end

  assign w_idle = (r_state == S_IDLE);
  assign w_go   = ex_valid & mem_en & ~ex_ale & ~older_ex & ~flush & (r_outst < MAX_C);

  // In IDLE the bus tracks the inputs; once a request is pending it replays the latched copy.
  assign data_sram_req   = (w_idle & w_go) | (r_state == S_REQ) | (r_state == S_CANCEL);
  assign data_sram_wr    = w_idle ? mem_we   : r_wr;
  assign data_sram_size  = w_idle ? mem_size : r_size;
  assign data_sram_wstrb = w_idle ? w_wstrb  : r_wstrb;
  assign data_sram_addr  = w_idle ? mem_addr : r_addr;
  assign data_sram_wdata = w_idle ? w_wdata  : r_wdata;

  assign w_hs = data_sram_req & data_sram_addr_ok;

  always_comb begin
    w_nstate = r_state;
    w_cinc   = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_go) w_nstate = data_sram_addr_ok ? (mem_allowin ? S_IDLE : S_WAIT) : S_REQ;
      S_REQ:
        if (flush) begin
          if (data_sram_addr_ok) begin
            w_nstate = S_IDLE;
            w_cinc   = 1'b1;
          end else w_nstate = S_CANCEL;
        end else if (data_sram_addr_ok) w_nstate = mem_allowin ? S_IDLE : S_WAIT;
      S_WAIT:
        if (flush) begin
          w_nstate = S_IDLE;
          w_cinc   = 1'b1;
        end else if (mem_allowin) w_nstate = S_IDLE;
      S_CANCEL:
        if (data_sram_addr_ok) begin
          w_nstate = S_IDLE;
          w_cinc   = 1'b1;
        end
    endcase
  end

  assign ex_ready_go = ~mem_en | ex_ale | older_ex
                     | ((w_idle | (r_state == S_REQ)) & w_hs)
                     | (r_state == S_WAIT);

  // Cancelled requests are always the youngest, so a drop fires once only they remain.
  assign w_drop       = data_sram_data_ok & (r_cancel != '0) & (r_cancel == r_outst);
  assign data_ok_drop = w_drop;
  assign outst_cnt    = r_outst;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_outst  <= '0;
      r_cancel <= '0;
      r_wr     <= 1'b0;
      r_size   <= 2'd0;
      r_wstrb  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_nstate;
      case ({w_hs, data_sram_data_ok})
        2'b10:   r_outst <= r_outst + CNT_W'(1);
        2'b01:   r_outst <= r_outst - CNT_W'(1);
        default: r_outst <= r_outst;
      endcase
      case ({w_cinc, w_drop})
        2'b10:   r_cancel <= r_cancel + CNT_W'(1);
        2'b01:   r_cancel <= r_cancel - CNT_W'(1);
        default: r_cancel <= r_cancel;
      endcase
      if (w_idle & w_go) begin
        r_wr    <= mem_we;
        r_size  <= mem_size;
        r_wstrb <= w_wstrb;
        r_addr  <= mem_addr;
        r_wdata <= w_wdata;
      end
    end
  end

`ifdef MEM_REQ_PERF_EN
  logic [31:0] r_perf_req, r_perf_wait;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_req  <= '0;
      r_perf_wait <= '0;
    end else begin
      if (w_hs) r_perf_req <= r_perf_req + 32'd1;
      if (data_sram_req & ~data_sram_addr_ok) r_perf_wait <= r_perf_wait + 32'd1;
    end
  end
  assign perf_req_cnt  = r_perf_req;
  assign perf_wait_cnt = r_perf_wait;
`else
  assign perf_req_cnt  = 32'd0;
  assign perf_wait_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_req_unit.sv
// Scenario bench for ex_mem_req_unit: 32-bit instance driven through scenarios,
// plus a 64-bit instance checked combinationally for dword strobes/ALE.
module tb_ex_mem_req_unit;
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid, mem_en, mem_we, flush, older_ex, mem_allowin;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, st_data;
  logic        req, wr, addr_ok, data_ok, ale, ready_go, drop;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata, perf_req, perf_wait;
  logic [1:0]  outst;

  logic        d_ex_valid, d_mem_en, d_mem_we;
  logic [1:0]  d_mem_size;
  logic [31:0] d_mem_addr;
  logic [63:0] d_st_data;
  logic        d_req, d_wr, d_ale, d_ready_go, d_drop;
  logic [1:0]  d_size, d_outst;
  logic [7:0]  d_wstrb;
  logic [31:0] d_addr, d_perf_req, d_perf_wait;
  logic [63:0] d_wdata;

  int   checks = 0;
  int   failures = 0;
  req_t q_exp[$];
  req_t sb_e;

  always #5 clk = ~clk;

  ex_mem_req_unit #(.DATA_W(32), .MAX_OUTST(2), .CNT_W(2)) u_dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .mem_en(mem_en), .mem_we(mem_we),
    .mem_size(mem_size), .mem_addr(mem_addr), .st_data(st_data), .flush(flush),
    .older_ex(older_ex), .mem_allowin(mem_allowin), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok),
    .ex_ale(ale), .ex_ready_go(ready_go), .data_ok_drop(drop), .outst_cnt(outst),
    .perf_req_cnt(perf_req), .perf_wait_cnt(perf_wait));

  ex_mem_req_unit #(.DATA_W(64), .MAX_OUTST(2), .CNT_W(2)) u_dut64 (
    .clk(clk), .resetn(resetn), .ex_valid(d_ex_valid), .mem_en(d_mem_en), .mem_we(d_mem_we),
    .mem_size(d_mem_size), .mem_addr(d_mem_addr), .st_data(d_st_data), .flush(1'b0),
    .older_ex(1'b0), .mem_allowin(1'b1), .data_sram_req(d_req), .data_sram_wr(d_wr),
    .data_sram_size(d_size), .data_sram_wstrb(d_wstrb), .data_sram_addr(d_addr),
    .data_sram_wdata(d_wdata), .data_sram_addr_ok(1'b0), .data_sram_data_ok(1'b0),
    .ex_ale(d_ale), .ex_ready_go(d_ready_go), .data_ok_drop(d_drop), .outst_cnt(d_outst),
    .perf_req_cnt(d_perf_req), .perf_wait_cnt(d_perf_wait));

  // Request scoreboard: every accepted handshake must match the oldest expected request.
  always @(negedge clk) begin
    if (resetn && req && addr_ok) begin
      checks++;
      if (q_exp.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_req got addr=%h", addr);
      end else begin
        sb_e = q_exp.pop_front();
        if ({wr, size, wstrb, addr, wdata} !== {sb_e.wr, sb_e.size, sb_e.wstrb, sb_e.addr, sb_e.wdata}) begin
          failures++;
          $display("FAIL sb_req got wr=%b sz=%0d strb=%h a=%h d=%h exp wr=%b sz=%0d strb=%h a=%h d=%h",
                   wr, size, wstrb, addr, wdata, sb_e.wr, sb_e.size, sb_e.wstrb, sb_e.addr, sb_e.wdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic en, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    ex_valid = v; mem_en = en; mem_we = we; mem_size = sz; mem_addr = a; st_data = d;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    flush = 0; older_ex = 0; mem_allowin = 1; addr_ok = 0; data_ok = 0;
    d_ex_valid = 0; d_mem_en = 0; d_mem_we = 0; d_mem_size = 0; d_mem_addr = 0; d_st_data = 0;
    step(); step();
    checks++; if (req !== 1'b0)        begin failures++; $display("FAIL rst_req got=%b exp=0", req); end
    checks++; if (ale !== 1'b0)        begin failures++; $display("FAIL rst_ale got=%b exp=0", ale); end
    checks++; if (ready_go !== 1'b1)   begin failures++; $display("FAIL rst_ready got=%b exp=1", ready_go); end
    checks++; if (drop !== 1'b0)       begin failures++; $display("FAIL rst_drop got=%b exp=0", drop); end
    checks++; if (outst !== 2'd0)      begin failures++; $display("FAIL rst_outst got=%0d exp=0", outst); end
    checks++; if (perf_req !== 32'd0 || perf_wait !== 32'd0) begin
      failures++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", perf_req, perf_wait); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_aligned_store();
    drive(1, 1, 1, 2'd1, 32'h1006, 32'h0000ABCD); addr_ok = 1; mem_allowin = 1;
    q_exp.push_back('{1'b1, 2'd1, 4'hC, 32'h1006, 32'hABCDABCD});
    #1;
    checks++; if (req !== 1'b1)           begin failures++; $display("FAIL st_req got=%b exp=1", req); end
    checks++; if (wstrb !== 4'hC)         begin failures++; $display("FAIL st_wstrb got=%h exp=c", wstrb); end
    checks++; if (wdata !== 32'hABCDABCD) begin failures++; $display("FAIL st_wdata got=%h exp=abcdabcd", wdata); end
    checks++; if (ready_go !== 1'b1)      begin failures++; $display("FAIL st_ready got=%b exp=1", ready_go); end
    step();
    drive(0, 0, 0, 0, 0, 0); addr_ok = 0; #1;
    checks++; if (outst !== 2'd1) begin failures++; $display("FAIL st_outst got=%0d exp=1", outst); end
    data_ok = 1; #1;
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL st_drop got=%b exp=0", drop); end
    step(); data_ok = 0; #1;
    checks++; if (outst !== 2'd0) begin failures++; $display("FAIL st_outst_ret got=%0d exp=0", outst); end
  endtask

  task automatic test_misaligned();
    drive(1, 1, 0, 2'd2, 32'h1002, 0); addr_ok = 1; #1;
    checks++; if (ale !== 1'b1)      begin failures++; $display("FAIL ale_word got=%b exp=1", ale); end
    checks++; if (req !== 1'b0)      begin failures++; $display("FAIL ale_req got=%b exp=0", req); end
    checks++; if (ready_go !== 1'b1) begin failures++; $display("FAIL ale_ready got=%b exp=1", ready_go); end
    step();
    checks++; if (outst !== 2'd0) begin failures++; $display("FAIL ale_outst got=%0d exp=0", outst); end
    drive(1, 1, 0, 2'd3, 32'h1000, 0); #1;
    checks++; if (ale !== 1'b1) begin failures++; $display("FAIL ale_dw32 got=%b exp=1", ale); end
    step();
    drive(1, 1, 0, 2'd2, 32'h1004, 0);
    q_exp.push_back('{1'b0, 2'd2, 4'h0, 32'h1004, 32'h0}); #1;
    checks++; if (ale !== 1'b0 || req !== 1'b1 || wstrb !== 4'h0) begin
      failures++; $display("FAIL ld_aligned got ale=%b req=%b strb=%h exp 0/1/0", ale, req, wstrb); end
    step();
    drive(0, 0, 0, 0, 0, 0); addr_ok = 0; data_ok = 1;
    step(); data_ok = 0;
  endtask

  task automatic test_backpressure();
    drive(1, 1, 1, 2'd2, 32'h2000, 32'h12345678); addr_ok = 0; mem_allowin = 1;
    q_exp.push_back('{1'b1, 2'd2, 4'hF, 32'h2000, 32'h12345678}); #1;
    checks++; if (req !== 1'b1 || addr !== 32'h2000 || ready_go !== 1'b0) begin
      failures++; $display("FAIL bp_c1 got req=%b addr=%h rdy=%b exp 1/2000/0", req, addr, ready_go); end
    step();
    mem_addr = 32'h3000; st_data = 32'hDEAD0000; #1;
    checks++; if (req !== 1'b1 || addr !== 32'h2000 || wdata !== 32'h12345678) begin
      failures++; $display("FAIL bp_c2 got req=%b addr=%h data=%h exp 1/2000/12345678", req, addr, wdata); end
    step();
    checks++; if (req !== 1'b1 || addr !== 32'h2000 || ready_go !== 1'b0) begin
      failures++; $display("FAIL bp_c3 got req=%b addr=%h rdy=%b exp 1/2000/0", req, addr, ready_go); end
    step();
`ifdef MEM_REQ_PERF_EN
    checks++; if (perf_wait !== 32'd3) begin failures++; $display("FAIL bp_perf_wait got=%0d exp=3", perf_wait); end
`else
    checks++; if (perf_wait !== 32'd0) begin failures++; $display("FAIL bp_perf_wait got=%0d exp=0", perf_wait); end
`endif
    addr_ok = 1; mem_allowin = 0; #1;
    checks++; if (ready_go !== 1'b1 || addr !== 32'h2000) begin
      failures++; $display("FAIL bp_accept got rdy=%b addr=%h exp 1/2000", ready_go, addr); end
    step();
    addr_ok = 0; #1;
    checks++; if (req !== 1'b0 || ready_go !== 1'b1 || outst !== 2'd1) begin
      failures++; $display("FAIL bp_wait got req=%b rdy=%b outst=%0d exp 0/1/1", req, ready_go, outst); end
    drive(0, 0, 0, 0, 0, 0); mem_allowin = 1;
    step(); data_ok = 1;
    step(); data_ok = 0; #1;
    checks++; if (outst !== 2'd0) begin failures++; $display("FAIL bp_outst got=%0d exp=0", outst); end
  endtask

  task automatic test_flush_req();
    drive(1, 1, 0, 2'd2, 32'h4000, 0); addr_ok = 0; mem_allowin = 1;
    q_exp.push_back('{1'b0, 2'd2, 4'h0, 32'h4000, 32'h0}); #1;
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL fl_req got=%b exp=1", req); end
    step();
    flush = 1; #1;
    checks++; if (req !== 1'b1 || ready_go !== 1'b0) begin
      failures++; $display("FAIL fl_req_state got req=%b rdy=%b exp 1/0", req, ready_go); end
    step();
    flush = 0; drive(1, 1, 0, 2'd2, 32'h5000, 0); #1;
    checks++; if (req !== 1'b1 || addr !== 32'h4000 || ready_go !== 1'b0) begin
      failures++; $display("FAIL fl_cancel got req=%b addr=%h rdy=%b exp 1/4000/0", req, addr, ready_go); end
    step();
    addr_ok = 1; #1;
    checks++; if (ready_go !== 1'b0) begin failures++; $display("FAIL fl_cancel_ok_rdy got=%b exp=0", ready_go); end
    step();
    drive(0, 0, 0, 0, 0, 0); addr_ok = 0; #1;
    checks++; if (outst !== 2'd1 || drop !== 1'b0) begin
      failures++; $display("FAIL fl_idle got outst=%0d drop=%b exp 1/0", outst, drop); end
    data_ok = 1; #1;
    checks++; if (drop !== 1'b1) begin failures++; $display("FAIL fl_drop got=%b exp=1", drop); end
    step(); data_ok = 0; #1;
    checks++; if (outst !== 2'd0) begin failures++; $display("FAIL fl_outst got=%0d exp=0", outst); end
  endtask

  task automatic test_outst_limit();
    addr_ok = 1; mem_allowin = 1;
    drive(1, 1, 0, 2'd2, 32'h6000, 0);
    q_exp.push_back('{1'b0, 2'd2, 4'h0, 32'h6000, 32'h0});
    step();
    drive(1, 1, 0, 2'd2, 32'h6004, 0);
    q_exp.push_back('{1'b0, 2'd2, 4'h0, 32'h6004, 32'h0});
    step();
    drive(1, 1, 0, 2'd2, 32'h6008, 0); #1;
    checks++; if (outst !== 2'd2) begin failures++; $display("FAIL lim_outst got=%0d exp=2", outst); end
    checks++; if (req !== 1'b0 || ready_go !== 1'b0) begin
      failures++; $display("FAIL lim_block got req=%b rdy=%b exp 0/0", req, ready_go); end
    step();
    data_ok = 1; #1;
    checks++; if (req !== 1'b0 || drop !== 1'b0) begin
      failures++; $display("FAIL lim_first_ok got req=%b drop=%b exp 0/0", req, drop); end
    step();
    q_exp.push_back('{1'b0, 2'd2, 4'h0, 32'h6008, 32'h0}); #1;
    checks++; if (req !== 1'b1 || ready_go !== 1'b1 || drop !== 1'b0) begin
      failures++; $display("FAIL lim_release got req=%b rdy=%b drop=%b exp 1/1/0", req, ready_go, drop); end
    step();
    drive(0, 0, 0, 0, 0, 0); addr_ok = 0; data_ok = 0; #1;
    checks++; if (outst !== 2'd1) begin failures++; $display("FAIL lim_simul got=%0d exp=1", outst); end
    data_ok = 1; #1;
    checks++; if (drop !== 1'b0) begin failures++; $display("FAIL lim_last_drop got=%b exp=0", drop); end
    step(); data_ok = 0; #1;
    checks++; if (outst !== 2'd0) begin failures++; $display("FAIL lim_outst_end got=%0d exp=0", outst); end
`ifdef MEM_REQ_PERF_EN
    checks++; if (perf_req !== 32'd7) begin failures++; $display("FAIL perf_req got=%0d exp=7", perf_req); end
`else
    checks++; if (perf_req !== 32'd0) begin failures++; $display("FAIL perf_req got=%0d exp=0", perf_req); end
`endif
  endtask

  task automatic test_dw64();
    d_ex_valid = 1; d_mem_en = 1; d_mem_we = 1; d_mem_size = 2'd3;
    d_mem_addr = 32'h20; d_st_data = 64'h1122334455667788; #1;
    checks++; if (d_ale !== 1'b0 || d_req !== 1'b1 || d_wstrb !== 8'hFF || d_wdata !== 64'h1122334455667788) begin
      failures++; $display("FAIL dw64_0x20 got ale=%b req=%b strb=%h d=%h exp 0/1/ff/1122334455667788",
                           d_ale, d_req, d_wstrb, d_wdata); end
    d_mem_addr = 32'h24; #1;
    checks++; if (d_ale !== 1'b1 || d_req !== 1'b0) begin
      failures++; $display("FAIL dw64_0x24 got ale=%b req=%b exp 1/0", d_ale, d_req); end
    d_mem_size = 2'd0; d_mem_addr = 32'h23; d_st_data = 64'hAB; #1;
    checks++; if (d_wstrb !== 8'h08 || d_wdata !== {8{8'hAB}}) begin
      failures++; $display("FAIL b64_0x23 got strb=%h d=%h exp 08/abab..", d_wstrb, d_wdata); end
    d_mem_size = 2'd1; d_mem_addr = 32'h26; #1;
    checks++; if (d_ale !== 1'b0 || d_wstrb !== 8'hC0) begin
      failures++; $display("FAIL h64_0x26 got ale=%b strb=%h exp 0/c0", d_ale, d_wstrb); end
    d_ex_valid = 0; d_mem_en = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_aligned_store();
    test_misaligned();
    test_backpressure();
    test_flush_req();
    test_outst_limit();
    test_dw64();
    step();
    checks++; if (q_exp.size() != 0) begin
      failures++; $display("FAIL sb_leftover got=%0d exp=0", q_exp.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
